// File: rtl/gpr_file_param.sv
// Parametrised GPR file: binary-indexed R/W, pair write/read, busy scoreboard, double-issue flag; writes land at clk edge, no backpressure.
// Define GPR_BYPASS_EN to forward same-cycle writeback data to reads and mask clearing busy bits out of stall.
module gpr_file_param #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int PAIR_LO  = 0,
  parameter int RPAIR_LO = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              pair_wr_en,
  input  logic [2*DW-1:0]   pair_wr_data,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  input  logic              rs1_re,
  input  logic              rs2_re,
  output logic [DW-1:0]     rs1_data,
  output logic [DW-1:0]     rs2_data,
  output logic [2*DW-1:0]   pair_rd_data,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  output logic [2**AW-1:0]  busy_vec,
  output logic              stall,
  output logic              err_dbl_issue
);

  localparam int NREG = 2**AW;
  localparam logic [AW-1:0] P_LO  = AW'(PAIR_LO);
  localparam logic [AW-1:0] P_HI  = AW'(PAIR_LO + 1);
  localparam logic [AW-1:0] RP_LO = AW'(RPAIR_LO);
  localparam logic [AW-1:0] RP_HI = AW'(RPAIR_LO + 1);

  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   view [NREG];
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] busy_eff;
  logic            wr_eff;

  // The pair write owns both pair registers; a single write aimed at either is dropped.
  assign wr_eff = wr_en & ~(pair_wr_en & ((wr_addr == P_LO) | (wr_addr == P_HI)));

  always_comb begin
    clr = '0;
    set = '0;
    for (int i = 0; i < NREG; i++) begin
      clr[i] = (wr_eff & (wr_addr == AW'(i)))
             | (pair_wr_en & ((AW'(i) == P_LO) | (AW'(i) == P_HI)));
      set[i] = issue_en & (issue_addr == AW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) view[i] = regs[i];
`ifdef GPR_BYPASS_EN
    if (wr_eff) view[wr_addr] = wr_data;
    if (pair_wr_en) begin
      view[P_LO] = pair_wr_data[DW-1:0];
      view[P_HI] = pair_wr_data[2*DW-1:DW];
    end
`endif
  end

`ifdef GPR_BYPASS_EN
  assign busy_eff = busy_vec & ~clr;
`else
  assign busy_eff = busy_vec;
`endif

  assign rs1_data     = view[rs1_addr];
  assign rs2_data     = view[rs2_addr];
  assign pair_rd_data = {view[RP_HI], view[RP_LO]};
  assign stall        = (rs1_re & busy_eff[rs1_addr]) | (rs2_re & busy_eff[rs2_addr]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy_vec      <= '0;
      err_dbl_issue <= 1'b0;
    end else begin
      if (wr_eff) regs[wr_addr] <= wr_data;
      if (pair_wr_en) begin
        regs[P_LO] <= pair_wr_data[DW-1:0];
        regs[P_HI] <= pair_wr_data[2*DW-1:DW];
      end
      // Issue outranks a same-cycle writeback, so the register stays pending.
      busy_vec      <= set | (busy_vec & ~clr);
      err_dbl_issue <= issue_en & busy_vec[issue_addr] & ~clr[issue_addr];
    end
  end

endmodule

// File: tb/tb_gpr_file_param.sv
// Self-checking bench for gpr_file_param: directed steps plus random traffic against an array-based model.
module tb_gpr_file_param;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NREG = 8;
  localparam int PAIR_LO = 0;
  localparam int RPAIR_LO = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, wr_en, pair_wr_en, rs1_re, rs2_re, issue_en;
  logic [AW-1:0]   wr_addr, rs1_addr, rs2_addr, issue_addr;
  logic [DW-1:0]   wr_data, rs1_data, rs2_data;
  logic [2*DW-1:0] pair_wr_data, pair_rd_data;
  logic [NREG-1:0] busy_vec;
  logic            stall, err_dbl_issue;

  gpr_file_param #(.DW(DW), .AW(AW), .PAIR_LO(PAIR_LO), .RPAIR_LO(RPAIR_LO)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pair_wr_en(pair_wr_en), .pair_wr_data(pair_wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_re(rs1_re), .rs2_re(rs2_re),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pair_rd_data(pair_rd_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(busy_vec), .stall(stall), .err_dbl_issue(err_dbl_issue)
  );

  // Model state: current contents, contents after this cycle's writes, and after reset.
  logic [DW-1:0]   m_reg [NREG];
  logic [DW-1:0]   w_reg [NREG];
  logic [DW-1:0]   n_reg [NREG];
  logic [NREG-1:0] m_busy, n_busy, m_clr;
  logic            m_err, n_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_pair(input int a);
    return (a == PAIR_LO) || (a == PAIR_LO + 1);
  endfunction

  task automatic predict();
    w_reg = m_reg;
    m_clr = '0;
    if (wr_en && !(pair_wr_en && in_pair(int'(wr_addr)))) begin
      w_reg[wr_addr] = wr_data;
      m_clr[wr_addr] = 1'b1;
    end
    if (pair_wr_en) begin
      w_reg[PAIR_LO]     = pair_wr_data[7:0];
      w_reg[PAIR_LO + 1] = pair_wr_data[15:8];
      m_clr[PAIR_LO]     = 1'b1;
      m_clr[PAIR_LO + 1] = 1'b1;
    end
    n_reg  = w_reg;
    n_busy = m_busy & ~m_clr;
    if (issue_en) n_busy[issue_addr] = 1'b1;
    n_err  = issue_en && m_busy[issue_addr] && !m_clr[issue_addr];
    if (rst) begin
      for (int i = 0; i < NREG; i++) n_reg[i] = '0;
      n_busy = '0;
      n_err  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0]   v [NREG];
    logic [NREG-1:0] bs;
`ifdef GPR_BYPASS_EN
    v  = w_reg;
    bs = m_busy & ~m_clr;
`else
    v  = m_reg;
    bs = m_busy;
`endif
    chk("rs1_data", 32'(rs1_data), 32'(v[rs1_addr]));
    chk("rs2_data", 32'(rs2_data), 32'(v[rs2_addr]));
    chk("pair_rd_data", 32'(pair_rd_data), 32'({v[RPAIR_LO + 1], v[RPAIR_LO]}));
    chk("stall", 32'(stall), 32'((rs1_re && bs[rs1_addr]) || (rs2_re && bs[rs2_addr])));
    chk("busy_vec", 32'(busy_vec), 32'(m_busy));
    chk("err_dbl_issue", 32'(err_dbl_issue), 32'(m_err));
  endtask

  task automatic step();
    #1;
    predict();
    check_outputs();
    @(posedge clk);
    m_reg  = n_reg;
    m_busy = n_busy;
    m_err  = n_err;
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; pair_wr_en = 0; issue_en = 0; rs1_re = 0; rs2_re = 0;
  endtask

  initial begin
    idle();
    rst = 1; wr_addr = '0; wr_data = '0; pair_wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; issue_addr = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_busy = '0; m_err = 1'b0;
    rst = 0;

    // Reset state on every index.
    for (int a = 0; a < NREG; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(NREG - 1 - a); rs1_re = 1; rs2_re = 1;
      #1;
      chk("reset_rs1", 32'(rs1_data), 32'h0);
      chk("reset_rs2", 32'(rs2_data), 32'h0);
      step();
    end
    chk("reset_busy", 32'(busy_vec), 32'h0);

    // Single write and read-after-write latency.
    idle();
    wr_en = 1; wr_addr = 3'd3; wr_data = 8'hA5; rs1_addr = 3'd3; rs2_addr = 3'd3;
    #1;
`ifdef GPR_BYPASS_EN
    chk("same_cycle_rd", 32'(rs1_data), 32'hA5);
`else
    chk("same_cycle_rd", 32'(rs1_data), 32'h00);
`endif
    step();
    idle();
    #1;
    chk("next_cycle_rd1", 32'(rs1_data), 32'hA5);
    chk("next_cycle_rd2", 32'(rs2_data), 32'hA5);
    step();

    // Pair write beats a colliding single write; then pair read.
    pair_wr_en = 1; pair_wr_data = 16'hBEEF; wr_en = 1; wr_addr = 3'd1; wr_data = 8'h11;
    step();
    idle();
    wr_en = 1; wr_addr = 3'd5; wr_data = 8'h55; step();
    wr_addr = 3'd6; wr_data = 8'h34; step();
    wr_addr = 3'd7; wr_data = 8'h12; step();
    idle();
    rs1_addr = 3'd0; rs2_addr = 3'd1;
    #1;
    chk("pair_r0", 32'(rs1_data), 32'hEF);
    chk("pair_r1", 32'(rs2_data), 32'hBE);
    chk("pair_rd", 32'(pair_rd_data), 32'h1234);
    step();

    // Scoreboard stall and release.
    issue_en = 1; issue_addr = 3'd2; step();
    idle();
    rs1_re = 1; rs1_addr = 3'd2;
    #1;
    chk("busy_r2", 32'(busy_vec), 32'h04);
    chk("stall_busy", 32'(stall), 32'h1);
    step();
    wr_en = 1; wr_addr = 3'd2; wr_data = 8'h22;
    #1;
`ifdef GPR_BYPASS_EN
    chk("stall_wb_cycle", 32'(stall), 32'h0);
`else
    chk("stall_wb_cycle", 32'(stall), 32'h1);
`endif
    step();
    wr_en = 0;
    #1;
    chk("stall_cleared", 32'(stall), 32'h0);
    step();

    // Double issue error, and issue coinciding with writeback.
    idle();
    issue_en = 1; issue_addr = 3'd4; step(); step();
    idle();
    #1;
    chk("dbl_issue_hi", 32'(err_dbl_issue), 32'h1);
    step();
    chk("dbl_issue_lo", 32'(err_dbl_issue), 32'h0);
    issue_en = 1; issue_addr = 3'd4; wr_en = 1; wr_addr = 3'd4; wr_data = 8'h44;
    step();
    idle();
    #1;
    chk("issue_wb_noerr", 32'(err_dbl_issue), 32'h0);
    chk("issue_wb_busy", 32'(busy_vec[4]), 32'h1);
    step();

    // Reset mid-stream discards pending state and a same-cycle write.
    issue_en = 1; issue_addr = 3'd1; step();
    issue_addr = 3'd5; step();
    idle();
    rst = 1; wr_en = 1; wr_addr = 3'd3; wr_data = 8'hFF; step();
    idle();
    rs1_addr = 3'd3; rs2_addr = 3'd5;
    #1;
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_r3", 32'(rs1_data), 32'h0);
    chk("rst_r5", 32'(rs2_data), 32'h0);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      wr_en        = $urandom_range(0, 1);
      wr_addr      = AW'($urandom_range(0, NREG - 1));
      wr_data      = DW'($urandom);
      pair_wr_en   = ($urandom_range(0, 3) == 0);
      pair_wr_data = 16'($urandom);
      rs1_addr     = AW'($urandom_range(0, NREG - 1));
      rs2_addr     = AW'($urandom_range(0, NREG - 1));
      rs1_re       = $urandom_range(0, 1);
      rs2_re       = $urandom_range(0, 1);
      issue_en     = ($urandom_range(0, 2) == 0);
      issue_addr   = AW'($urandom_range(0, NREG - 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_file_param.md
Name: gpr_file_param

Overview:
Parametrised successor to the core's fixed 8x8 general-purpose register file. Uses binary-indexed read/write ports instead of one-hot selects. Adds a 2*DW pair write and a pair read port, a per-register busy scoreboard for in-flight writebacks, and a registered double-issue error flag. Sits between the decoder (read/issue side) and the writeback stage.

Parameters:
DW, 8, data width of each register in bits
AW, 3, register index width; NREG = 2**AW registers
PAIR_LO, 0, index of the low register for pair write; PAIR_LO+1 is the high register; must be even and < NREG-1
RPAIR_LO, 6, index of the low register for pair read; RPAIR_LO+1 is the high register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  single-register writeback enable
wr_addr  in  AW  writeback register index
wr_data  in  DW  writeback data
pair_wr_en  in  1  pair writeback enable
pair_wr_data  in  2*DW  [DW-1:0] goes to PAIR_LO, [2DW-1:DW] goes to PAIR_LO+1
rs1_addr  in  AW  read port 1 index
rs2_addr  in  AW  read port 2 index
rs1_re  in  1  read port 1 in use (for stall)
rs2_re  in  1  read port 2 in use (for stall)
rs1_data  out  DW  read port 1 data (combinational)
rs2_data  out  DW  read port 2 data (combinational)
pair_rd_data  out  2*DW  {R[RPAIR_LO+1], R[RPAIR_LO]}
issue_en  in  1  mark issue_addr busy (destination of newly issued instr)
issue_addr  in  AW  destination index being issued
busy_vec  out  NREG  registered scoreboard, bit i = R[i] pending
stall  out  1  combinational: (rs1_re & busy[rs1_addr]) | (rs2_re & busy[rs2_addr])
err_dbl_issue  out  1  registered one-cycle pulse: issue to an already-busy register

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- On reset: all registers = 0, busy_vec = 0, err_dbl_issue = 0. Outputs follow, so rs1_data = rs2_data = pair_rd_data = 0 and stall = 0.
- Write takes effect at the clock edge; the read in the following cycle returns the new value.
- Write priority:
  - If pair_wr_en, R[PAIR_LO] and R[PAIR_LO+1] take pair_wr_data.
  - wr_en to a register outside the pair still writes in the same cycle.
  - wr_en to PAIR_LO or PAIR_LO+1 while pair_wr_en is high is ignored; the pair wins.
- Reads: rs1_data = R[rs1_addr], rs2_data = R[rs2_addr]. Both ports are independent; the same index on both is legal.
- Scoreboard update per bit i, evaluated each edge:
  - clr_i = (wr_en & wr_addr==i & !(pair_wr_en & i in pair)) | (pair_wr_en & i in pair).
  - set_i = issue_en & issue_addr==i.
  - busy_i next = set_i | (busy_i & !clr_i). Issue wins over a same-cycle writeback to the same index, leaving the register busy again.
- err_dbl_issue next = issue_en & busy[issue_addr] & !clr[issue_addr].
  - Issue on the same cycle as the clearing writeback is not an error.
  - The pulse lasts one cycle per offending issue; back-to-back offending issues keep it high.
- A writeback to a non-busy register is legal and silent; busy stays 0.
- stall uses the current busy_vec (before any same-cycle clear) unless GPR_BYPASS_EN is defined.
- No wrap or overflow arithmetic. All indices are in range by construction.
- Reset mid-operation drops all pending busy bits and data. No writeback is remembered.

Optional Feature:
GPR_BYPASS_EN
- Defined:
  - Read ports forward same-cycle writeback data. If wr_en (effective, after pair priority) and wr_addr==rsN_addr, rsN_data = wr_data. If pair_wr_en hits rsN_addr, rsN_data = the matching pair_wr_data half.
  - pair_rd_data forwards the same way, per half.
  - stall masks busy bits being cleared this cycle: uses busy & ~clr.
- Undefined: reads return stored register contents only; stall uses raw busy_vec. Adds one cycle of read-after-writeback latency.

Test Plan:
- Reset, then read all 8 indices on both ports -> every rs1_data/rs2_data = 0x00, busy_vec = 0x00, stall = 0, err_dbl_issue = 0.
- wr_en addr 3 data 0xA5, next cycle rs1_addr=3 rs2_addr=3 -> both read 0xA5. With GPR_BYPASS_EN, the same-cycle read already returns 0xA5; without it, the same-cycle read returns 0x00.
- pair_wr_en data 0xBEEF plus wr_en addr 1 data 0x11 and wr_en to addr 5 is a separate cycle -> R0=0xEF, R1=0xBE (the addr-1 write is dropped). Writes R6=0x34, R7=0x12 -> pair_rd_data = 0x1234.
- issue_en addr 2, then rs1_re=1 rs1_addr=2 -> busy_vec=0x04, stall=1. wr_en addr 2 -> busy clears next cycle, stall=0. With bypass, stall=0 already in the writeback cycle.
- issue_en addr 4 twice on consecutive cycles with no writeback -> err_dbl_issue=1 for exactly one cycle after the second issue. Issue addr 4 again in the same cycle as a wr_en addr 4 -> no error, busy[4] stays 1.
- Set busy on R1 and R5, assert rst for one cycle mid-stream, with a wr_en on the same cycle -> after reset busy_vec=0, all registers 0, the write discarded.
